conv_window_buffer: RTL and testbench

Streaming 3x3 sliding-window generator that sits directly downstream of the pixel normalizer and feeds the first convolution layer. It accepts one normalized Q8.8 pixel per valid cycle in raster order. It stores the two previous image rows in on-chip line buffers and emits a full 3x3 neighbourhood whenever the current pixel completes a window lying entirely inside the image (valid convolution, no padding).

---
 rtl/conv_window_buffer.sv | 110 +++++++++++
 tb/tb_conv_window_buffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/conv_window_buffer.sv
// Streaming 3x3 sliding-window generator over a raster-ordered pixel stream.
// Two line buffers hold the previous rows; a window is emitted only when it lies fully inside the image.
module conv_window_buffer #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [DATA_W-1:0]     pixel_in,
   output logic                  valid_out,
   output logic [9*DATA_W-1:0]   window_out,
   output logic                  frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic              accept;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic              valid_out_q, frame_done_q;
   logic              win_valid, last_pixel;

   assign accept     = valid_in & ~rst;
   assign win_valid  = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
   assign last_pixel = (row_q == ROW_LAST) && (col_q == COL_LAST);

   // col_d also serves as the line-buffer read address for the next accepted pixel.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (rst) begin
         col_d = '0;
         row_d = '0;
      end else if (valid_in) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         valid_out_q  <= win_valid;
         frame_done_q <= win_valid && last_pixel;
      end
   end

   // Line buffers with registered read. The read prefetches the next column, so the
   // registered data always mirrors mem[col_q]; the write goes to col_q, never the read address.
   logic [DATA_W-1:0] lb0_mem [IMG_W];
   logic [DATA_W-1:0] lb1_mem [IMG_W];
   logic [DATA_W-1:0] lb0_rd_q, lb1_rd_q;

   always_ff @(posedge clk) begin
      if (accept) begin
         lb0_mem[col_q] <= lb1_rd_q;
         lb1_mem[col_q] <= pixel_in;
      end
      lb0_rd_q <= lb0_mem[col_d];
      lb1_rd_q <= lb1_mem[col_d];
   end

   logic [DATA_W-1:0] col_new [3];
   assign col_new[0] = lb0_rd_q;
   assign col_new[1] = lb1_rd_q;
   assign col_new[2] = pixel_in;

   // One shift register per window row i; column 2 takes the freshly arrived pixel of that row.
   genvar gi, gj;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_row
         logic [DATA_W-1:0] tap_q [3];

         always_ff @(posedge clk) begin
            if (rst) begin
               tap_q[0] <= '0;
               tap_q[1] <= '0;
               tap_q[2] <= '0;
            end else if (accept) begin
               tap_q[0] <= tap_q[1];
               tap_q[1] <= tap_q[2];
               tap_q[2] <= col_new[gi];
            end
         end

         for (gj = 0; gj < 3; gj++) begin : g_col
            assign window_out[DATA_W*(3*gi+gj) +: DATA_W] = tap_q[gj];
         end
      end
   endgenerate

   assign valid_out  = valid_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench: a 4x4 instance for the directed scenarios and a default 28x28 instance
// for a random frame, both checked against a frame-image window extraction model.
module tb_conv_window_buffer;

   localparam int SW = 4;
   localparam int SH = 4;
   localparam int LW = 28;
   localparam int LH = 28;
   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_s, vin_s, vout_s, fd_s;
   logic [DW-1:0] pin_s;
   logic [143:0]  win_s;
   logic          rst_l, vin_l, vout_l, fd_l;
   logic [DW-1:0] pin_l;
   logic [143:0]  win_l;

   conv_window_buffer #(.IMG_W(SW), .IMG_H(SH), .DATA_W(DW)) dut_s (
      .clk(clk), .rst(rst_s), .valid_in(vin_s), .pixel_in(pin_s),
      .valid_out(vout_s), .window_out(win_s), .frame_done(fd_s));

   conv_window_buffer dut_l (
      .clk(clk), .rst(rst_l), .valid_in(vin_l), .pixel_in(pin_l),
      .valid_out(vout_l), .window_out(win_l), .frame_done(fd_l));

   typedef struct packed {
      logic [143:0] win;
      logic         fd;
   } exp_t;

   exp_t          q_s[$];
   exp_t          q_l[$];
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] img [2][LH][LW];
   int            m_row [2];
   int            m_col [2];
   int            nwin [2];
   int            nfd [2];

   function automatic void check(string name, logic [143:0] act, logic [143:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endfunction

   // Reference: remember the frame as an image; a window is the 3x3 block ending at (r,c).
   function automatic void model_pixel(int s, logic [DW-1:0] v);
      int   w = (s != 0) ? LW : SW;
      int   h = (s != 0) ? LH : SH;
      int   r = m_row[s];
      int   c = m_col[s];
      exp_t e;
      img[s][r][c] = v;
      if (r >= 2 && c >= 2) begin
         e.win = '0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               e.win[DW*(3*i+j) +: DW] = img[s][r-2+i][c-2+j];
         e.fd = (r == h - 1) && (c == w - 1);
         if (s != 0) q_l.push_back(e);
         else        q_s.push_back(e);
      end
      m_col[s] = c + 1;
      if (m_col[s] == w) begin
         m_col[s] = 0;
         m_row[s] = (r + 1 == h) ? 0 : r + 1;
      end
   endfunction

   task automatic send(int s, logic [DW-1:0] v);
      if (s != 0) begin vin_l = 1'b1; pin_l = v; end
      else        begin vin_s = 1'b1; pin_s = v; end
      @(posedge clk);
      model_pixel(s, v);
      #1;
      vin_s = 1'b0;
      vin_l = 1'b0;
   endtask

   task automatic gap(int s, int n);
      logic [143:0] w0;
      w0 = (s != 0) ? win_l : win_s;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      check($sformatf("dut%0d.hold_window", s), (s != 0) ? win_l : win_s, w0);
   endtask

   task automatic mon(int s, logic v, logic f, logic [143:0] w);
      exp_t e;
      bit   have;
      have = (s != 0) ? (q_l.size() > 0) : (q_s.size() > 0);
      if (have) begin
         if (s != 0) e = q_l.pop_front();
         else        e = q_s.pop_front();
         check($sformatf("dut%0d.valid_out", s), {143'd0, v}, 144'd1);
         check($sformatf("dut%0d.window", s), w, e.win);
         check($sformatf("dut%0d.frame_done", s), {143'd0, f}, {143'd0, e.fd});
      end else begin
         check($sformatf("dut%0d.idle_valid", s), {143'd0, v}, 144'd0);
         check($sformatf("dut%0d.idle_frame_done", s), {143'd0, f}, 144'd0);
      end
      if (v === 1'b1) nwin[s]++;
      if (f === 1'b1) nfd[s]++;
   endtask

   always @(negedge clk) begin
      mon(0, vout_s, fd_s, win_s);
      mon(1, vout_l, fd_l, win_l);
   end

   initial begin
      rst_s = 1'b1; vin_s = 1'b0; pin_s = '0;
      rst_l = 1'b1; vin_l = 1'b0; pin_l = '0;
      for (int s = 0; s < 2; s++) begin
         m_row[s] = 0; m_col[s] = 0; nwin[s] = 0; nfd[s] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("reset.window_s", win_s, 144'd0);
      check("reset.window_l", win_l, 144'd0);
      check("reset.valid_s", {143'd0, vout_s}, 144'd0);
      check("reset.frame_done_s", {143'd0, fd_s}, 144'd0);
      rst_s = 1'b0;
      rst_l = 1'b0;

      // Basic frame, continuous valid.
      for (int idx = 0; idx < 16; idx++) send(0, DW'(idx << 8));

      // Same frame with random bubbles.
      for (int idx = 0; idx < 16; idx++) begin
         if ($urandom_range(0, 1) == 1) gap(0, int'($urandom_range(1, 3)));
         send(0, DW'(idx << 8));
      end

      // Two frames back to back, no gap at the boundary.
      for (int f = 0; f < 2; f++)
         for (int idx = 0; idx < 16; idx++)
            send(0, DW'(((f * 100) + idx) << 8));

      // Abort mid-frame; the pixel presented with rst must be dropped.
      for (int idx = 0; idx < 10; idx++) send(0, DW'(idx << 8));
      rst_s = 1'b1; vin_s = 1'b1; pin_s = 16'hBEEF;
      @(posedge clk);
      #1;
      rst_s = 1'b0; vin_s = 1'b0;
      m_row[0] = 0; m_col[0] = 0;
      check("rst_mid.window", win_s, 144'd0);
      check("rst_mid.valid", {143'd0, vout_s}, 144'd0);
      for (int idx = 0; idx < 16; idx++) send(0, DW'(idx << 8));

      // Default-size frame with random data and occasional bubbles.
      for (int p = 0; p < LW * LH; p++) begin
         if ($urandom_range(0, 15) == 0) gap(1, int'($urandom_range(1, 3)));
         send(1, DW'($urandom));
      end

      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("count.windows_s", 144'(nwin[0]), 144'd20);
      check("count.frame_done_s", 144'(nfd[0]), 144'd5);
      check("count.windows_l", 144'(nwin[1]), 144'd676);
      check("count.frame_done_l", 144'(nfd[1]), 144'd1);
      check("count.pending", 144'(q_s.size() + q_l.size()), 144'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
